// File: rtl/javk_bus_mem.sv
// javk_bus_mem: responding end of the JAVK CPU bus.
// On-chip RAM plus a two-register console port (CON_DATA / CON_STAT) whose
// writes feed a TX FIFO drained by an external valid/ready consumer.
// State changes on negedge clk (the CPU's control edge); the read data
// register updates on posedge so the CPU can sample it at the next negedge.
// Optional feature: define JAVK_MEM_WP_EN to make RAM below WP_LIMIT
// read-only and report attempted writes through the sticky wp_fault flag.
module javk_bus_mem #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [15:0] RAM_BASE   = 16'h0000,
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] WP_LIMIT   = 16'h0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addrbus,
  input  logic        rw,
  inout  wire  [7:0]  databus,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        wp_fault
);

  localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RAM_BYTES = 1 << ADDR_WIDTH;

  logic [7:0]    ram [0:RAM_BYTES-1];
  logic [7:0]    fifo_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0] wr_ptr_next, rd_ptr_next;
  logic [3:0]    count_reg, count_next;
  logic          overflow_reg;
  logic [15:0]   addr_reg;
  logic [7:0]    rdata_reg;
  logic [7:0]    head_next;
  logic [7:0]    wdata;
  logic [7:0]    status;

  logic ram_sel, io_data_sel, io_stat_sel, ram_sel_q;
  logic we, full, empty, pop, push_req, push, flush, stat_wr;
  logic wp_block, ram_we;

  // RAM_BASE is aligned to the RAM size, so only the upper bits need matching.
  assign ram_sel     = (addrbus[15:ADDR_WIDTH] == RAM_BASE[15:ADDR_WIDTH]);
  assign io_data_sel = (addrbus == IO_BASE);
  assign io_stat_sel = (addrbus == IO_BASE + 16'd1);
  assign ram_sel_q   = (addr_reg[15:ADDR_WIDTH] == RAM_BASE[15:ADDR_WIDTH]);

  assign wdata    = databus;
  assign we       = rw && !rst;
  assign full     = (count_reg == 4'(FIFO_DEPTH));
  assign empty    = (count_reg == 4'd0);
  assign pop      = con_valid && con_ready;
  assign push_req = we && io_data_sel;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push     = push_req && (!full || pop);
  assign stat_wr  = we && io_stat_sel;
  assign flush    = stat_wr && wdata[0];
  assign ram_we   = we && ram_sel && !wp_block;
  assign status   = {count_reg, overflow_reg, wp_fault, empty, full};

  // Release the bus except on reads of a mapped address.
  assign databus = (!rst && !rw && (ram_sel || io_data_sel || io_stat_sel)) ? rdata_reg : 8'bz;

  // Next pointers, count and the head byte that con_data will show.
  always_comb begin
    rd_ptr_next = pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
    wr_ptr_next = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    count_next  = count_reg + {3'b000, push} - {3'b000, pop};
    head_next   = 8'h00;
    if (!flush && count_next != 4'd0) begin
      // The byte being pushed is the new head if it lands where the read pointer goes.
      if (push && wr_ptr_reg == rd_ptr_next)
        head_next = wdata;
      else
        head_next = fifo_mem[rd_ptr_next];
    end
  end

  // FIFO control and registered handshake outputs.
  always_ff @(negedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= 4'd0;
      overflow_reg <= 1'b0;
      con_valid    <= 1'b0;
      con_data     <= 8'h00;
    end else begin
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= 4'd0;
        con_valid  <= 1'b0;
        con_data   <= 8'h00;
      end else begin
        wr_ptr_reg <= wr_ptr_next;
        rd_ptr_reg <= rd_ptr_next;
        count_reg  <= count_next;
        con_valid  <= (count_next != 4'd0);
        con_data   <= head_next;
      end
      if (stat_wr && wdata[1])
        overflow_reg <= 1'b0;
      else if (push_req && full && !pop)
        overflow_reg <= 1'b1;
    end
  end

  // FIFO storage write.
  always_ff @(negedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= wdata;
  end

  // RAM write on the CPU control edge.
  always_ff @(negedge clk) begin
    if (ram_we)
      ram[addrbus[ADDR_WIDTH-1:0]] <= wdata;
  end

  // Capture the read address at the control edge.
  always_ff @(negedge clk) begin
    addr_reg <= addrbus;
  end

  // Registered read data, ready for the CPU at the following negedge.
  always_ff @(posedge clk) begin
    if (rst)
      rdata_reg <= 8'h00;
    else if (ram_sel_q)
      rdata_reg <= ram[addr_reg[ADDR_WIDTH-1:0]];
    else if (addr_reg == IO_BASE + 16'd1)
      rdata_reg <= status;
    else
      rdata_reg <= 8'h00;
  end

`ifdef JAVK_MEM_WP_EN
  assign wp_block = (addrbus < WP_LIMIT);

  // Sticky fault on a blocked RAM write; cleared by reset or CON_STAT bit2.
  always_ff @(negedge clk) begin
    if (rst)
      wp_fault <= 1'b0;
    else if (we && ram_sel && wp_block)
      wp_fault <= 1'b1;
    else if (stat_wr && wdata[2])
      wp_fault <= 1'b0;
  end
`else
  logic unused_wp_limit;
  // WP_LIMIT only matters when write protection is built in.
  assign unused_wp_limit = ^WP_LIMIT;
  assign wp_block        = 1'b0;
  assign wp_fault        = 1'b0;
`endif

endmodule

// File: tb/tb_javk_bus_mem.sv
// Bench for javk_bus_mem: directed cases with literal expectations, then a
// randomized run checked against a queue/array model of the bus responder.
module tb_javk_bus_mem;

  localparam logic [15:0] IO_BASE   = 16'hFF00;
  localparam int          DEPTH     = 8;
  localparam logic [15:0] WPL       = 16'h0400;
  localparam int          RAM_BYTES = 4096;
  localparam logic [15:0] IDLE_ADDR = 16'h8000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addrbus = 16'h0123;
  logic        rw = 1'b0;
  logic        con_ready = 1'b0;
  wire  [7:0]  databus;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        wp_fault;
  logic        drive_en = 1'b0;
  logic [7:0]  dbus_drv = 8'h00;

  assign databus = drive_en ? dbus_drv : 8'bz;

  // Released bus reads as 8'hFF.
  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_pu
    pullup pu (databus[gi]);
  end

  always #5 clk = ~clk;

  javk_bus_mem #(
    .ADDR_WIDTH(12), .RAM_BASE(16'h0000), .IO_BASE(IO_BASE),
    .FIFO_DEPTH(DEPTH), .WP_LIMIT(WPL)
  ) dut (
    .clk(clk), .rst(rst), .addrbus(addrbus), .rw(rw), .databus(databus),
    .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready),
    .wp_fault(wp_fault)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_ram [0:RAM_BYTES-1];
  bit         m_written [0:RAM_BYTES-1];
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_wpf = 1'b0;
  int         wr_list[$];

  function automatic logic [7:0] m_stat();
    return {4'(q.size()), m_ovf, m_wpf, (q.size() == 0), (q.size() == DEPTH)};
  endfunction

  always @(negedge clk) begin : model
    int         a;
    logic [7:0] d;
    a = int'(addrbus);
    d = databus;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_wpf = 1'b0;
    end else begin
      if (q.size() > 0 && con_ready)
        void'(q.pop_front());
      if (rw) begin
        if (a < RAM_BYTES) begin
`ifdef JAVK_MEM_WP_EN
          if (a < int'(WPL)) m_wpf = 1'b1;
          else begin
            m_ram[a] = d;
            if (!m_written[a]) begin m_written[a] = 1'b1; wr_list.push_back(a); end
          end
`else
          m_ram[a] = d;
          if (!m_written[a]) begin m_written[a] = 1'b1; wr_list.push_back(a); end
`endif
        end else if (a == int'(IO_BASE)) begin
          if (q.size() < DEPTH) q.push_back(d);
          else m_ovf = 1'b1;
        end else if (a == int'(IO_BASE) + 1) begin
          if (d[0]) q.delete();
          if (d[1]) m_ovf = 1'b0;
`ifdef JAVK_MEM_WP_EN
          if (d[2]) m_wpf = 1'b0;
`endif
        end
      end
    end
  end

  // Every-cycle comparison of the handshake outputs against the model.
  bit chk_on = 1'b0;
  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      chk1("con_valid", con_valid, q.size() != 0);
      if (q.size() != 0) chk8("con_data", con_data, q[0]);
      chk1("wp_fault", wp_fault, m_wpf);
    end
  end

  // Consumer: 0 = never ready, 1 = always ready, 2 = ready one cycle in four.
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    con_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) == 0) : (rdy_mode == 1);
  end

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addrbus = a; rw = 1'b1; dbus_drv = d; drive_en = 1'b1;
    @(negedge clk); #1;
    rw = 1'b0; drive_en = 1'b0; addrbus = IDLE_ADDR;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    addrbus = a; rw = 1'b0;
    @(negedge clk);
    @(posedge clk); #2;
    d = databus;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d, old;
    logic [15:0] a;
    int          op;

    // Reset: bus must stay released while rst is high, even on a RAM read.
    repeat (3) @(posedge clk);
    #2;
    chk8("bus_in_reset", databus, 8'hFF);
    @(posedge clk); #1;
    rst = 1'b0; addrbus = IDLE_ADDR;
    @(negedge clk); #1;
    chk1("rst_con_valid", con_valid, 1'b0);
    chk8("rst_con_data", con_data, 8'h00);
    chk1("rst_wp_fault", wp_fault, 1'b0);
    chk_on = 1'b1;
    bus_read(IO_BASE + 16'd1, d);  chk8("rst_stat", d, 8'h02);

    // RAM and address map boundaries.
    bus_write(16'h0123, 8'hA5);
    bus_read(16'h0123, d);          chk8("ram_a5", d, 8'hA5);
    bus_write(16'h0FFF, 8'h3C);
    bus_read(16'h0FFF, d);          chk8("ram_top", d, 8'h3C);
    bus_read(16'h1000, d);          chk8("past_ram_z", d, 8'hFF);
    bus_read(16'h8000, d);          chk8("unmapped_z", d, 8'hFF);
    bus_write(16'h8000, 8'h77);
    bus_read(16'h0123, d);          chk8("unmapped_wr_ram", d, 8'hA5);
    bus_read(IO_BASE + 16'd1, d);   chk8("unmapped_wr_stat", d, 8'h02);
    bus_read(IO_BASE + 16'd2, d);   chk8("io_plus2_z", d, 8'hFF);
    bus_read(IO_BASE, d);           chk8("con_data_rd", d, 8'h00);

    // Fill past capacity with no consumer.
    for (int i = 1; i <= 9; i++) bus_write(IO_BASE, 8'(i));
    bus_read(IO_BASE + 16'd1, d);   chk8("stat_full_ovf", d, 8'h89);
    chk8("head_first", con_data, 8'h01);
    rdy_mode = 1;
    @(posedge clk); #2;
    for (int i = 1; i <= 8; i++) begin
      chk1("drain_valid", con_valid, 1'b1);
      chk8("drain_order", con_data, 8'(i));
      @(posedge clk); #2;
    end
    chk1("drain_empty", con_valid, 1'b0);
    rdy_mode = 0;
    bus_write(IO_BASE + 16'd1, 8'h02);
    bus_read(IO_BASE + 16'd1, d);   chk8("ovf_cleared", d, 8'h02);

    // Full FIFO with push and pop on the same edge.
    for (int i = 0; i < 8; i++) bus_write(IO_BASE, 8'(8'h10 + i));
    rdy_mode = 1;
    bus_write(IO_BASE, 8'h55);
    rdy_mode = 0;
    bus_read(IO_BASE + 16'd1, d);   chk8("full_push_pop", d, 8'h81);
    chk8("full_push_pop_head", con_data, 8'h11);

    // Flush with three entries queued.
    bus_write(IO_BASE + 16'd1, 8'h01);
    bus_write(IO_BASE, 8'hAA);
    bus_write(IO_BASE, 8'hBB);
    bus_write(IO_BASE, 8'hCC);
    bus_read(IO_BASE + 16'd1, d);   chk8("three_queued", d, 8'h30);
    bus_write(IO_BASE + 16'd1, 8'h03);
    bus_read(IO_BASE + 16'd1, d);   chk8("flushed", d, 8'h02);
    chk1("flushed_valid", con_valid, 1'b0);

    // Reset arriving during a CON_DATA write discards the write.
    bus_write(IO_BASE, 8'h66);
    @(posedge clk); #1;
    rst = 1'b1; addrbus = IO_BASE; rw = 1'b1; dbus_drv = 8'h77; drive_en = 1'b1;
    @(negedge clk); #1;
    rw = 1'b0; drive_en = 1'b0; addrbus = IDLE_ADDR;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_read(IO_BASE + 16'd1, d);   chk8("rst_mid_write", d, 8'h02);

`ifdef JAVK_MEM_WP_EN
    bus_read(16'h0010, old);
    bus_write(16'h0010, 8'hFF);
    bus_read(16'h0010, d);          chk8("wp_readback", d, old);
    chk1("wp_fault_set", wp_fault, 1'b1);
    bus_read(IO_BASE + 16'd1, d);   chk8("wp_stat", d, 8'h06);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #2;
    chk1("wp_after_rst", wp_fault, 1'b0);
    bus_write(WPL, 8'h5A);
    bus_read(WPL, d);               chk8("wp_limit_writable", d, 8'h5A);
    bus_write(WPL - 16'd1, 8'h11);
    chk1("wp_below_limit", wp_fault, 1'b1);
    bus_write(IO_BASE + 16'd1, 8'h04);
    bus_read(IO_BASE + 16'd1, d);   chk8("wp_stat_clear", d, 8'h02);
`else
    bus_write(16'h0010, 8'hFF);
    bus_read(16'h0010, d);          chk8("nowp_write", d, 8'hFF);
    chk1("nowp_fault", wp_fault, 1'b0);
    bus_read(IO_BASE + 16'd1, d);   chk8("nowp_stat", d, 8'h02);
`endif

    // Randomized traffic against the model.
    rdy_mode = 2;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        a = ($urandom_range(0, 1) == 0) ? 16'(16'h03F8 + $urandom_range(0, 15))
                                        : 16'(16'h0FF8 + $urandom_range(0, 15));
        bus_write(a, 8'($urandom_range(0, 255)));
      end else if (op <= 4) begin
        if (wr_list.size() > 0) begin
          a = 16'(wr_list[$urandom_range(0, wr_list.size() - 1)]);
          bus_read(a, d);
          chk8("rand_ram", d, m_ram[a]);
        end
      end else if (op <= 6) begin
        bus_write(IO_BASE, 8'($urandom_range(0, 255)));
      end else if (op == 7) begin
        d = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) != 0) d[0] = 1'b0;
        bus_write(IO_BASE + 16'd1, d);
      end else if (op == 8) begin
        bus_read(IO_BASE + 16'd1, d);
        chk8("rand_stat", d, m_stat());
      end else begin
        case ($urandom_range(0, 3))
          0:       a = 16'h8000;
          1:       a = IO_BASE + 16'd2;
          2:       a = 16'h1000;
          default: a = IO_BASE - 16'd1;
        endcase
        bus_read(a, d);
        chk8("rand_unmapped", d, 8'hFF);
      end
    end
    rdy_mode = 0;
    @(posedge clk); #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
